// File: rtl/ad7265_pkg.sv
// Shared constants and FSM state type for the AD7265 serial controller.
// Frame bit positions are numbered 31 (leading zero) down to 0.
package ad7265_pkg;

    localparam int FRAME_BITS = 32;
    localparam int RES_MSB    = 29;
    localparam int RES_LSB    = 18;
    localparam int RES_W      = RES_MSB - RES_LSB + 1;

    // Frame bits that the ADC always drives as zero: bit 30 and bits 17:14.
    localparam logic [FRAME_BITS-1:0] ZERO_MASK = 32'h4003_C000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOW,
        ST_HIGH,
        ST_QUIET
    } ad7265_state_t;

endpackage

// File: rtl/ad7265_clkdiv.sv
// Purpose: half-period counter producing a one-cycle half_tick enable for SCLK.
// Latency: first tick CLK_DIV cycles after en rises, then every CLK_DIV cycles.
// Backpressure: none; counter holds at zero while en is low.
module ad7265_clkdiv #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic half_tick
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    assign half_tick = en && (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || half_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ad7265_ctrl.sv
// Purpose: AD7265 dual-ADC serial master; one 32-SCLK frame per accepted start.
// Latency: data_valid and ncs rise 65*CLK_DIV+1 cycles after the accept edge.
// Backpressure: start ignored while busy (frame plus QUIET_CYCLES); no queueing.
module ad7265_ctrl
    import ad7265_pkg::*;
#(
    parameter int CLK_DIV      = 2,
    parameter int QUIET_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       addr_in,
    input  logic             rng_in,
    output logic             busy,
    output logic             adc_sclk,
    output logic             ncs,
    output logic [2:0]       adc_addr,
    output logic             rng,
    input  logic             douta,
    input  logic             doutb,
    output logic [RES_W-1:0] data_a,
    output logic [RES_W-1:0] data_b,
    output logic [2:0]       data_addr,
    output logic             data_err,
    output logic             data_valid
);

    localparam int QW = $clog2(QUIET_CYCLES + 1);

    ad7265_state_t           state_q, state_d;
    logic [5:0]              bit_cnt;
    logic [QW-1:0]           quiet_cnt;
    logic [FRAME_BITS-1:0]   sr_a, sr_b;
    logic                    half_tick;
    logic                    div_en;
    logic                    accept, sample, frame_done, quiet_done;

    assign div_en = (state_q == ST_SETUP) || (state_q == ST_LOW) || (state_q == ST_HIGH);

    ad7265_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (div_en),
        .half_tick (half_tick)
    );

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        sample     = 1'b0;
        frame_done = 1'b0;
        quiet_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (half_tick) state_d = ST_LOW;
            end
            ST_LOW: begin
                if (half_tick) begin
                    sample  = 1'b1;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (half_tick) begin
                    if (bit_cnt == 6'(FRAME_BITS)) begin
                        frame_done = 1'b1;
                        state_d    = ST_QUIET;
                    end else begin
                        state_d = ST_LOW;
                    end
                end
            end
            ST_QUIET: begin
                if (quiet_cnt == QW'(QUIET_CYCLES - 1)) begin
                    quiet_done = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame bit 31 is never sampled, so shift-register bit b+1 holds frame bit b.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            busy       <= 1'b0;
            adc_sclk   <= 1'b1;
            ncs        <= 1'b1;
            adc_addr   <= '0;
            rng        <= 1'b0;
            bit_cnt    <= '0;
            quiet_cnt  <= '0;
            sr_a       <= '0;
            sr_b       <= '0;
            data_a     <= '0;
            data_b     <= '0;
            data_addr  <= '0;
            data_err   <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            adc_sclk   <= (state_d != ST_LOW);
            ncs        <= (state_d == ST_IDLE) || (state_d == ST_QUIET);
            data_valid <= frame_done;
            if (accept) begin
                adc_addr <= addr_in;
                rng      <= rng_in;
                busy     <= 1'b1;
                bit_cnt  <= '0;
            end
            if (sample) begin
                sr_a    <= {sr_a[FRAME_BITS-2:0], douta};
                sr_b    <= {sr_b[FRAME_BITS-2:0], doutb};
                bit_cnt <= bit_cnt + 6'd1;
            end
            if (frame_done) begin
                data_a    <= sr_a[RES_MSB+1:RES_LSB+1];
                data_b    <= sr_b[RES_MSB+1:RES_LSB+1];
                data_addr <= adc_addr;
                data_err  <= |((sr_a | sr_b) & (ZERO_MASK << 1));
                quiet_cnt <= '0;
            end else if (state_q == ST_QUIET) begin
                quiet_cnt <= quiet_cnt + 1'b1;
            end
            if (quiet_done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ad7265_ctrl.sv
// Directed bench for ad7265_ctrl with a behavioural AD7265 pin model.
// Outputs are sampled on the falling clk edge; cycle 1 is the first sample after accept.
module tb_ad7265_ctrl;

    localparam int D = 2;
    localparam int Q = 4;
    localparam int LAT = 65 * D + 1;

    logic        clk, rst_n, start, rng_in, busy, adc_sclk, ncs, rng;
    logic [2:0]  addr_in, adc_addr, data_addr;
    logic        douta, doutb, data_err, data_valid;
    logic [11:0] data_a, data_b;

    ad7265_ctrl #(.CLK_DIV(D), .QUIET_CYCLES(Q)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .addr_in    (addr_in),
        .rng_in     (rng_in),
        .busy       (busy),
        .adc_sclk   (adc_sclk),
        .ncs        (ncs),
        .adc_addr   (adc_addr),
        .rng        (rng),
        .douta      (douta),
        .doutb      (doutb),
        .data_a     (data_a),
        .data_b     (data_b),
        .data_addr  (data_addr),
        .data_err   (data_err),
        .data_valid (data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // ADC model: leading zero at ncs fall, next bit on every SCLK fall, 1s once released.
    logic [11:0] din_a [8];
    logic [11:0] din_b [8];
    bit          err16 = 0;
    logic [31:0] fa, fb;
    int          bidx = 0;
    int          fall_cnt = 0;

    function automatic logic [31:0] mk_frame(input logic [11:0] res, input logic [11:0] other);
        return {2'b00, res, 4'b0000, other, 2'b00};
    endfunction

    initial begin
        douta = 1'b0;
        doutb = 1'b0;
    end

    always @(negedge ncs or negedge adc_sclk) begin
        if (!ncs) begin
            if (adc_sclk) begin
                fa = mk_frame(din_a[adc_addr], ~din_a[adc_addr]);
                fa[16] = err16;
                fb = mk_frame(din_b[adc_addr], ~din_b[adc_addr]);
                bidx = 31;
            end else begin
                fall_cnt++;
                bidx--;
            end
            douta = (bidx >= 0) ? fa[bidx] : 1'b1;
            doutb = (bidx >= 0) ? fb[bidx] : 1'b1;
        end
    end

    // Passive monitors: data_valid count, ncs-high run length, SCLK idle level.
    int dv_cnt = 0;
    int hi_run = 0;
    int last_gap = 0;
    bit sclk_bad = 0;

    always @(negedge clk) begin
        if (data_valid) dv_cnt++;
        if (ncs && !adc_sclk) sclk_bad = 1;
        if (ncs) begin
            hi_run++;
        end else begin
            if (hi_run > 0) last_gap = hi_run;
            hi_run = 0;
        end
    end

    task automatic run_frame(input string tag, input logic [2:0] a, input logic r,
                             input logic [11:0] ea, input logic [11:0] eb, input logic ee,
                             input bit pulse_mid, input bit chk_gap);
        int cyc;
        int f0;
        bit hold_bad;
        f0 = fall_cnt;
        @(negedge clk);
        addr_in = a;
        rng_in  = r;
        start   = 1'b1;
        cyc = 0;
        while (ncs && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_accept"}, {31'd0, ncs}, 32'd0);
        addr_in  = ~a;
        rng_in   = ~r;
        cyc      = 1;
        hold_bad = 0;
        while (!data_valid && cyc < 400) begin
            if (!ncs && (adc_addr !== a || rng !== r)) hold_bad = 1;
            if (pulse_mid) start = (cyc == 10 || cyc == 60);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_latency"}, cyc, LAT);
        check({tag, "_data_a"}, {20'd0, data_a}, {20'd0, ea});
        check({tag, "_data_b"}, {20'd0, data_b}, {20'd0, eb});
        check({tag, "_data_addr"}, {29'd0, data_addr}, {29'd0, a});
        check({tag, "_data_err"}, {31'd0, data_err}, {31'd0, ee});
        check({tag, "_ncs_rise"}, {31'd0, ncs}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_addr_rng_hold"}, {31'd0, hold_bad}, 32'd0);
        check({tag, "_sclk_falls"}, fall_cnt - f0, 32);
        if (chk_gap) check({tag, "_quiet_gap"}, {31'd0, last_gap >= Q + 1}, 32'd1);
        @(negedge clk);
        check({tag, "_dv_strobe"}, {31'd0, data_valid}, 32'd0);
    endtask

    initial begin
        int d0;
        int cyc;
        rst_n   = 1'b0;
        start   = 1'b0;
        addr_in = 3'd0;
        rng_in  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            din_a[i] = 12'hA5A;
            din_b[i] = 12'h3C3;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ncs", {31'd0, ncs}, 32'd1);
        check("rst_sclk", {31'd0, adc_sclk}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_outs", {data_a, data_b, data_addr, data_err, adc_addr, rng},
              32'd0);
        d0 = dv_cnt;
        repeat (200) @(negedge clk);
        check("idle_no_dv", dv_cnt - d0, 0);
        check("idle_ncs", {31'd0, ncs}, 32'd1);

        run_frame("basic", 3'd5, 1'b1, 12'hA5A, 12'h3C3, 1'b0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            din_a[i] = 12'h100 + 12'(i);
            din_b[i] = 12'h200 + 12'(i);
        end
        for (int i = 0; i < 8; i++) begin
            run_frame("sweep", 3'(i), 1'(i & 1), din_a[i], din_b[i], 1'b0, 0, i > 0);
        end

        d0 = dv_cnt;
        run_frame("ignore", 3'd3, 1'b0, din_a[3], din_b[3], 1'b0, 1, 0);
        repeat (150) @(negedge clk);
        check("ignore_one_dv", dv_cnt - d0, 1);
        check("ignore_no_frame", {31'd0, ncs}, 32'd1);

        @(negedge clk);
        addr_in = 3'd1;
        start   = 1'b1;
        cyc = 0;
        while (ncs && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        cyc = 1;
        while (cyc < 70) begin
            @(negedge clk);
            cyc++;
        end
        d0 = dv_cnt;
        rst_n = 1'b0;
        #1;
        check("midrst_ncs", {31'd0, ncs}, 32'd1);
        check("midrst_sclk", {31'd0, adc_sclk}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_data_a", {20'd0, data_a}, 32'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("midrst_no_dv", dv_cnt - d0, 0);
        run_frame("post_rst", 3'd2, 1'b1, din_a[2], din_b[2], 1'b0, 0, 0);

        err16 = 1;
        run_frame("err", 3'd6, 1'b0, din_a[6], din_b[6], 1'b1, 0, 0);
        err16 = 0;
        run_frame("clean", 3'd6, 1'b0, din_a[6], din_b[6], 1'b0, 0, 1);

        check("sclk_high_when_ncs_high", {31'd0, sclk_bad}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ad7265_ctrl.md
# ad7265_ctrl

- Synchronous master for the AD7265 dual 12-bit SAR ADC serial interface.
- Per accepted request, runs one 32-SCLK frame: drives `ncs`, `adc_sclk`, `adc_addr` and `rng`, and shifts in `douta`/`doutb` simultaneously.
- Presents one 12-bit result per line with the address tag and a framing-error flag.
- Sits between the driver-board housekeeping sequencer (issues `start`) and the ADC pins.

## Interface
Parameters:
- `CLK_DIV`, 2: `clk` cycles per SCLK half-period, ≥2. At 50 MHz, 2 gives a 12.5 MHz SCLK (40 ns half-period, above the 36 ns ADC output delay).
- `QUIET_CYCLES`, 4: `clk` cycles with `ncs` high after a frame before the next `start` is accepted, ≥1.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: async active-low reset.
- `start` in 1: request a conversion; sampled only in IDLE.
- `addr_in` in 3: channel-pair address, latched on accept.
- `rng_in` in 1: range select, latched on accept.
- `busy` out 1: high from accept through end of QUIET.
- `adc_sclk` out 1: serial clock, idles high.
- `ncs` out 1: chip select, active low.
- `adc_addr` out 3: latched address, held for the whole frame.
- `rng` out 1: latched range, held for the whole frame.
- `douta`, `doutb` in 1: ADC serial data.
- `data_a`, `data_b` out 12: results.
- `data_addr` out 3: address tag of the results.
- `data_err` out 1: framing error for the last frame.
- `data_valid` out 1: one-cycle strobe; results update on the same cycle.

## Operation
- Reset values: `ncs`=1, `adc_sclk`=1, `adc_addr`=0, `rng`=0, `busy`=0, `data_a`/`data_b`=0, `data_addr`=0, `data_err`=0, `data_valid`=0. FSM goes to IDLE.
- FSM states and transitions:
  - IDLE: on `start`=1, latch `addr_in`/`rng_in`, set `busy`, go to SETUP. `ncs` falls on the next edge.
  - SETUP: one half-period with `ncs` low and SCLK high, then go to LOW.
  - LOW: SCLK low for one half-period. The ADC shifts out the next bit on this falling edge.
  - HIGH: on entry (the `clk` edge that drives SCLK high), sample `douta`/`doutb` into two 32-bit shift registers, MSB first, and increment `bit_cnt`.
    - If `bit_cnt` < 32 after the half-period, return to LOW.
    - Otherwise drive `ncs` high, assert `data_valid`, and go to QUIET.
  - QUIET: hold for `QUIET_CYCLES`, clear `busy`, return to IDLE.
- Sample k (k=1..32) holds frame bit 31−k.
- Frame layout per line:
  - bit 31: leading zero, not sampled.
  - bit 30: zero.
  - bits 29:18: result, MSB first (samples 2..13).
  - bits 17:14: zeros.
  - bits 13:2: the other channel's result, ignored.
  - bits 1:0: zero.
- Sample 32 is taken after the ADC releases the bus and is don't-care.
- `data_a` comes from `douta` bits 29:18 and `data_b` from `doutb` bits 29:18. `data_addr` = the latched `adc_addr`.
- `data_err` = OR over both lines of frame bits 30, 17, 16, 15 and 14. It updates with `data_valid`.
- `start` while `busy` is ignored; there is no queueing. `addr_in`/`rng_in` changes mid-frame have no effect.
- `rst_n` asserted mid-frame: outputs return to reset values at once (`ncs` high), with no `data_valid`. After release, `start` is accepted from IDLE.
- `douta`/`doutb` sampling is unsynchronised. The ADC is source-synchronous to `adc_sclk`, so hold time is guaranteed by half-period ≥ t_dout.

## Timing
- SCLK period = 2·`CLK_DIV` cycles with a 50% duty cycle. All pin outputs are registered.
- Accept edge = cycle 0; `ncs` low from cycle 1.
- `ncs` low for 65·`CLK_DIV` cycles: `CLK_DIV` for SETUP, then 32 LOW/HIGH pairs of 2·`CLK_DIV` each.
- `ncs` rises and `data_valid` pulses on cycle 65·`CLK_DIV`+1, which is 131 for `CLK_DIV`=2.
- Earliest next accept: `QUIET_CYCLES` cycles after the `data_valid` cycle.
- Exactly 32 SCLK falling edges per frame. SCLK is high whenever `ncs` is high.

## Structure
- Package `ad7265_pkg`:
  - `FRAME_BITS`=32, `RES_MSB`=29, `RES_LSB`=18.
  - Zero-bit mask constant covering bits 30 and 17:14.
  - FSM state enum `ad7265_state_t`.
- Sub-module `ad7265_clkdiv`: half-period counter producing a one-cycle `half_tick` enable. The controller toggles SCLK on that tick.

## Test plan
- Reset release, no `start` → `ncs`=1, `adc_sclk`=1, `busy`=0, `data_valid` never asserts for 200 cycles.
- ADC model loaded with `din_a` entries 0xA5A and `din_b` entries 0x3C3, `addr_in`=5, `rng_in`=1, `start` → exactly 32 SCLK falls; `data_valid` at cycle 131; `data_a`=0xA5A, `data_b`=0x3C3, `data_addr`=5, `data_err`=0; `adc_addr`=5 and `rng`=1 stable while `ncs` is low.
- Distinct entries 0x100+i per channel, sweep `addr_in` 0..7 back-to-back → each result equals the model entry mapped for that `adc_addr`; gap between `ncs` rise and next `ncs` fall is ≥ `QUIET_CYCLES`+1.
- `start` pulsed at cycles 10 and 60 during a frame → ignored; one `data_valid` only.
- `rst_n` low at cycle 70 of a frame → `ncs` high and SCLK high in the same cycle; no `data_valid`; next `start` yields a correct frame.
- Model forces frame bit 16 of `douta` to 1 → `data_err`=1 with `data_valid`; the next clean frame gives `data_err`=0.
